// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - COPY/FILL block mover driving one RAM read port and one write port
module ram_block_mover #(
    parameter int RAM_WIDTH      = 64,
    parameter int RAM_DEPTH      = 128,
    parameter int RAM_IDX_WIDTH  = $clog2(RAM_DEPTH),
    parameter int RAM_WIDTH_BYTE = RAM_WIDTH / 8,
    parameter int LEN_WIDTH      = RAM_IDX_WIDTH + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic [RAM_IDX_WIDTH-1:0]  cmd_src_idx,
    input  logic [RAM_IDX_WIDTH-1:0]  cmd_dst_idx,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic [RAM_WIDTH-1:0]      cmd_fill_data,
    input  logic [RAM_WIDTH_BYTE-1:0] cmd_mask,
    output logic                      busy,
    output logic                      done,
    input  logic                      r_grant,
    output logic                      r_en,
    output logic [RAM_IDX_WIDTH-1:0]  r_ram_idx,
    input  logic [RAM_WIDTH-1:0]      r_data,
    output logic                      w_en,
    output logic [RAM_IDX_WIDTH-1:0]  w_ram_idx,
    output logic [RAM_WIDTH-1:0]      w_data,
    output logic [RAM_WIDTH_BYTE-1:0] w_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic                      op_q;
    logic [RAM_IDX_WIDTH-1:0]  src_q, dst_q;
    logic [LEN_WIDTH-1:0]      len_q, issued_q, remain_q;
    logic [RAM_WIDTH-1:0]      fill_q;
    logic [RAM_WIDTH_BYTE-1:0] mask_q;
    logic                      rd_pend_q;

    logic accept, issue, fill_wr, wr_any;

    always_comb begin
        accept  = (state == S_IDLE) && cmd_valid;
        issue   = (state == S_RUN) && !op_q && r_grant && (issued_q < len_q);
        fill_wr = (state == S_RUN) && op_q;
        // rd_pend is only ever set by a COPY read, so it alone marks a write-back
        wr_any  = fill_wr || rd_pend_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (op_q) begin
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_nxt = S_DONE;
                    end
                end else if ((issued_q + LEN_WIDTH'(issue)) == len_q) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            remain_q  <= '0;
            fill_q    <= '0;
            mask_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_pend_q <= issue;
            if (accept) begin
                op_q     <= cmd_op;
                src_q    <= cmd_src_idx;
                dst_q    <= cmd_dst_idx;
                len_q    <= cmd_len;
                issued_q <= '0;
                remain_q <= cmd_len;
                fill_q   <= cmd_fill_data;
                mask_q   <= cmd_mask;
            end else begin
                if (issue) begin
                    src_q    <= src_q + RAM_IDX_WIDTH'(1);
                    issued_q <= issued_q + LEN_WIDTH'(1);
                end
                if (wr_any) begin
                    dst_q <= dst_q + RAM_IDX_WIDTH'(1);
                end
                if (fill_wr) begin
                    remain_q <= remain_q - LEN_WIDTH'(1);
                end
            end
        end
    end

    // Outputs are forced quiet during reset, even before the state register has cleared
    always_comb begin
        cmd_ready = !reset && (state == S_IDLE);
        busy      = !reset && (state != S_IDLE);
        done      = !reset && (state == S_DONE);
        r_en      = !reset && issue;
        r_ram_idx = r_en ? src_q : '0;
        w_en      = !reset && wr_any;
        w_ram_idx = w_en ? dst_q : '0;
        w_mask    = w_en ? mask_q : '0;
        w_data    = '0;
        if (w_en) begin
            w_data = fill_wr ? fill_q : r_data;
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - self-checking bench for ram_block_mover against a RAM model and command model
module tb_ram_block_mover;

    localparam int W  = 64;
    localparam int D  = 128;
    localparam int IW = 7;
    localparam int BW = 8;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [IW-1:0] cmd_src_idx = '0;
    logic [IW-1:0] cmd_dst_idx = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [W-1:0]  cmd_fill_data = '0;
    logic [BW-1:0] cmd_mask = '0;
    logic          busy, done;
    logic          r_grant = 1'b1;
    logic          r_en;
    logic [IW-1:0] r_ram_idx;
    logic [W-1:0]  r_data = '0;
    logic          w_en;
    logic [IW-1:0] w_ram_idx;
    logic [W-1:0]  w_data;
    logic [BW-1:0] w_mask;

    ram_block_mover dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_idx(cmd_src_idx), .cmd_dst_idx(cmd_dst_idx), .cmd_len(cmd_len),
        .cmd_fill_data(cmd_fill_data), .cmd_mask(cmd_mask),
        .busy(busy), .done(done),
        .r_grant(r_grant), .r_en(r_en), .r_ram_idx(r_ram_idx), .r_data(r_data),
        .w_en(w_en), .w_ram_idx(w_ram_idx), .w_data(w_data), .w_mask(w_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_t;

    logic [63:0] ram [D];
    logic [63:0] mdl [D];
    wr_t         wq[$];
    int          rq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    logic        copy_mode = 1'b0;
    logic        prev_r_en = 1'b0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // RAM: 1-cycle read latency with same-cycle write-to-read bypass
    always @(posedge clock) begin
        logic [63:0] rd;
        if (r_en) begin
            rd = ram[r_ram_idx];
            if (w_en && (w_ram_idx == r_ram_idx)) rd = merge(rd, w_data, w_mask);
            r_data <= rd;
        end
        if (w_en) ram[w_ram_idx] <= merge(ram[w_ram_idx], w_data, w_mask);
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("reset_quiet", {42'd0, cmd_ready, busy, done, r_en, w_en, 1'b0, |r_ram_idx, |w_ram_idx, |w_data, |w_mask}, 64'd0);
            prev_r_en <= 1'b0;
        end else begin
            chk("busy_vs_ready", busy, !cmd_ready);
            if (!r_en) chk("r_idx_idle", r_ram_idx, 0);
            else begin
                chk("read_needs_grant", r_grant, 1);
                if (rq.size() == 0) chk("unexpected_read", r_en, 0);
                else chk("read_idx", r_ram_idx, rq.pop_front());
            end
            if (!w_en) chk("w_idle_zero", {w_ram_idx, w_data, w_mask} == '0, 1);
            else if (wq.size() == 0) chk("unexpected_write", w_en, 0);
            else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_idx", w_ram_idx, e.idx);
                chk("write_data", w_data, e.data);
                chk("write_mask", w_mask, e.mask);
                mdl[e.idx] = merge(mdl[e.idx], e.data, e.mask);
            end
            if (copy_mode) chk("writeback_follows_read", w_en, prev_r_en);
            if (done) done_cnt++;
            prev_r_en <= r_en;
        end
    end

    task automatic preload(input int idx, input logic [63:0] v);
        ram[idx] = v;
        mdl[idx] = v;
    endtask

    // Expected command effect: element-wise ascending, each read sees all earlier writes
    task automatic prep(input logic op, input int src, input int dst, input int len,
                        input logic [63:0] fill, input logic [7:0] mask);
        logic [63:0] tmp [D];
        tmp = mdl;
        for (int i = 0; i < len; i++) begin
            wr_t e;
            int s, d;
            s = (src + i) % D;
            d = (dst + i) % D;
            e.idx  = d;
            e.data = op ? fill : tmp[s];
            e.mask = mask;
            wq.push_back(e);
            tmp[d] = merge(tmp[d], e.data, mask);
            if (!op) rq.push_back(s);
        end
        copy_mode = !op;
    endtask

    task automatic accept(input logic op, input int src, input int dst, input int len,
                          input logic [63:0] fill, input logic [7:0] mask);
        @(negedge clock);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_src_idx = IW'(src);
        cmd_dst_idx = IW'(dst);
        cmd_len = LW'(len);
        cmd_fill_data = fill;
        cmd_mask = mask;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic op, input int src, input int dst, input int len,
                           input logic [63:0] fill, input logic [7:0] mask,
                           input logic [15:0] gpat, input int glen, output int lat);
        int mism;
        prep(op, src, dst, len, fill, mask);
        accept(op, src, dst, len, fill, mask);
        lat = 0;
        forever begin
            r_grant = (lat < glen) ? gpat[lat] : 1'b1;
            @(negedge clock);
            lat++;
            if (done) break;
            if (lat > 300) begin
                chk("done_timeout", lat, 0);
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("writes_all_issued", wq.size(), 0);
        chk("reads_all_issued", rq.size(), 0);
        mism = 0;
        for (int i = 0; i < D; i++) if (ram[i] !== mdl[i]) mism++;
        chk("ram_vs_model", mism, 0);
        copy_mode = 1'b0;
        r_grant = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int lat, d0;
        for (int i = 0; i < D; i++) preload(i, 64'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // FILL with wrap 126,127,0,1
        run_cmd(1'b1, 0, 126, 4, {16{4'hA, 4'h5}}, 8'hFF, 16'h0, 0, lat);
        chk("fill_latency", lat, 5);
        chk("fill_126", ram[126], 64'hA5A5A5A5A5A5A5A5);
        chk("fill_127", ram[127], 64'hA5A5A5A5A5A5A5A5);
        chk("fill_0", ram[0], 64'hA5A5A5A5A5A5A5A5);
        chk("fill_1", ram[1], 64'hA5A5A5A5A5A5A5A5);
        chk("fill_2_untouched", ram[2], 64'd0);

        // COPY 0..7 -> 32..39 with full grant
        for (int i = 0; i < 8; i++) preload(i, 64'h11 * i);
        run_cmd(1'b0, 0, 32, 8, 64'd0, 8'hFF, 16'h0, 0, lat);
        chk("copy8_latency", lat, 10);
        for (int i = 0; i < 8; i++) chk("copy8_data", ram[32 + i], 64'h11 * i);

        // COPY with grant pattern 1,0,0,1,1,0,1 (bit0 first)
        for (int i = 0; i < 4; i++) preload(80 + i, 64'hC0DE_0000 + i);
        run_cmd(1'b0, 80, 90, 4, 64'd0, 8'hFF, 16'b1011001, 7, lat);
        chk("gated_latency", lat, 9);
        chk("gated_last", ram[93], 64'hC0DE_0003);

        // Masked COPY
        preload(50, 64'h1122_3344_5566_7788);
        preload(60, 64'hFFFF_FFFF_FFFF_FFFF);
        run_cmd(1'b0, 50, 60, 1, 64'd0, 8'h0F, 16'h0, 0, lat);
        chk("masked_latency", lat, 3);
        chk("masked_data", ram[60], 64'hFFFF_FFFF_5566_7788);

        // Overlapping forward COPY smears entry 10
        preload(10, 64'h1);
        for (int i = 11; i < 15; i++) preload(i, 64'hDEAD);
        run_cmd(1'b0, 10, 11, 4, 64'd0, 8'hFF, 16'h0, 0, lat);
        chk("overlap_latency", lat, 6);
        for (int i = 11; i < 15; i++) chk("overlap_smear", ram[i], 64'h1);

        // Zero length
        run_cmd(1'b0, 3, 4, 0, 64'd0, 8'hFF, 16'h0, 0, lat);
        chk("zero_len_latency", lat, 1);

        // Reset in cycle 3 of a len-8 COPY
        for (int i = 0; i < 8; i++) preload(40 + i, 64'h100 + 64'(40 + i));
        for (int i = 0; i < 8; i++) preload(64 + i, 64'd0);
        d0 = done_cnt;
        prep(1'b0, 40, 64, 8, 64'd0, 8'hFF);
        accept(1'b0, 40, 64, 8, 64'd0, 8'hFF);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_busy", busy, 0);
        chk("writes_left_after_abort", wq.size(), 7);
        chk("reads_left_after_abort", rq.size(), 6);
        wq.delete();
        rq.delete();
        copy_mode = 1'b0;
        repeat (4) @(negedge clock);
        chk("no_done_after_abort", done_cnt, d0);
        chk("abort_first_written", ram[64], 64'h128);
        chk("abort_second_unwritten", ram[65], 64'd0);

        run_cmd(1'b1, 0, 100, 3, 64'h0123_4567_89AB_CDEF, 8'hF0, 16'h0, 0, lat);
        chk("fill_after_reset_latency", lat, 4);
        chk("fill_after_reset_data", ram[102], 64'h0123_4567_0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- DMA-style initiator that drives one read port and one write port of the multi-port byte-masked RAM (LVT RAM, 1-cycle read latency, same-cycle write→read bypass).
- Executes COPY (RAM→RAM, ascending) or FILL (constant pattern) commands over an index range, with wrap-around at RAM_DEPTH.
- Used for cache line init, scrub and migration; a port arbiter lends it the read port via r_grant.

Parameters:
- RAM_WIDTH, 64, data width in bits; must be a power of two and at least 8.
- RAM_DEPTH, 128, number of entries; must be a power of two.
- RAM_IDX_WIDTH, $clog2(RAM_DEPTH), index width.
- RAM_WIDTH_BYTE, RAM_WIDTH/8, number of mask bits.
- LEN_WIDTH, RAM_IDX_WIDTH+1, command length width, so length ranges over 0..RAM_DEPTH.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = COPY, 1 = FILL.
- cmd_src_idx  in  RAM_IDX_WIDTH  first source index (COPY only).
- cmd_dst_idx  in  RAM_IDX_WIDTH  first destination index.
- cmd_len  in  LEN_WIDTH  number of entries to move.
- cmd_fill_data  in  RAM_WIDTH  FILL pattern.
- cmd_mask  in  RAM_WIDTH_BYTE  byte mask applied to every write.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- r_grant  in  1  arbiter permits a read issue this cycle.
- r_en  out  1  RAM read enable.
- r_ram_idx  out  RAM_IDX_WIDTH  RAM read index.
- r_data  in  RAM_WIDTH  RAM read data, valid the cycle after r_en.
- w_en  out  1  RAM write enable.
- w_ram_idx  out  RAM_IDX_WIDTH  RAM write index.
- w_data  out  RAM_WIDTH  RAM write data.
- w_mask  out  RAM_WIDTH_BYTE  RAM byte mask.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, all counters cleared, rd_pend = 0. While reset is high: cmd_ready = 0, busy = 0, done = 0, r_en = 0, w_en = 0, all index/data/mask outputs = 0.
- Reset asserted mid-command aborts the command: no done pulse, no further RAM accesses from the next cycle on. Partially written entries stay as written.
- Accept: a command is taken when cmd_valid && cmd_ready in IDLE. All cmd_* fields are latched at that edge.
- Zero length: cmd_len = 0 goes to DONE with no RAM access; done pulses the cycle after accept.
- FILL, state RUN:
  - Each cycle: w_en = 1, w_ram_idx = dst, w_data = fill pattern, w_mask = latched mask. Then dst++ and remaining--.
  - Ignores r_grant; r_en stays 0.
  - Goes to DONE after the write with remaining = 1.
  - Throughput is 1 entry/cycle, so total latency from accept to done is len + 1 cycles.
- COPY, state RUN:
  - Read issue: when r_grant && issued < len, drive r_en = 1, r_ram_idx = src; then src++ and issued++.
  - Write-back: rd_pend is the registered copy of r_en. When rd_pend = 1, drive w_en = 1, w_ram_idx = dst, w_data = r_data, w_mask = latched mask; then dst++.
  - r_grant low only suppresses new reads. A write-back already pending always issues.
  - Once issued == len, go to DRAIN.
- DRAIN: one cycle that performs the final write-back, then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Index arithmetic: src and dst wrap modulo RAM_DEPTH, e.g. RAM_DEPTH-1 + 1 → 0. The r_ram_idx and w_ram_idx outputs are never out of range.
- Overlap is defined as element-wise ascending copy using the RAM's bypass:
  - When dst = src + k (0 < k < len), the read of entry i in cycle t coincides with the write of entry i-1. Source data is therefore replicated with period k (memmove-forward smear).
  - dst < src copies correctly.
  - Software must split commands if it wants a true memmove.
- Unused outputs: when r_en = 0, r_ram_idx = 0. When w_en = 0, w_ram_idx, w_data and w_mask are 0.
- Outputs are registered-state driven. r_en may depend combinationally on r_grant.

Test Plan:
- FILL: dst = 126, len = 4, data = 0xA5A5…, mask = 0xFF on RAM_DEPTH = 128 → writes to 126, 127, 0, 1 in consecutive cycles; done 5 cycles after accept; the 4 entries read back as 0xA5A5….
- COPY: src = 0..7 preloaded with i*0x11, dst = 32, len = 8, r_grant = 1 → reads in cycles 1–8, writes in cycles 2–9, done in cycle 10; entries 32..39 = i*0x11.
- COPY, len = 4, r_grant toggling 1,0,0,1,1,0,1 → exactly 4 reads and 4 writes, each write one cycle after its read; data correct; done only after the last write.
- Masked COPY: mask = 0x0F, dst preloaded with 0xFFFF_FFFF_FFFF_FFFF, src = 0x1122_3344_5566_7788 → dst = 0xFFFF_FFFF_5566_7788.
- Overlap COPY: src = 10, dst = 11, len = 4, entry 10 = 0x1 → entries 11..14 all = 0x1. Zero-length command → done the cycle after accept, no w_en/r_en.
- Reset asserted in cycle 3 of a len-8 COPY → the next cycle shows IDLE, cmd_ready = 1, no done pulse; a subsequent FILL executes normally.
